vector_mask_encoder: RTL and testbench
======================================

Name: vector_mask_encoder

Overview:
- Inverse of the per-word mask decode path: packs per-byte-lane compare results (vmseq/vmslt-class ops) into a VLEN-bit mask, one bit per element.
- Emits finished mask words, 32 bits at a time, toward the vector register file write port.
- Element width encodings match the mask decoder: 000 = 8b, 101 = 16b, 110 = 32b; any other code is treated as 8b.

Parameters:
- VLEN, 256, vector register length in bits; must be a multiple of 32.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  one-cycle pulse; latches i_vl and i_element_width and begins a mask build
- i_vl  in  $clog2(VLEN)+1  element count (0..VLEN)
- i_element_width  in  3  SEW code
- i_cmp_valid  in  1  compare word valid
- o_cmp_ready  out  1  encoder accepts compare word
- i_cmp_bits  in  4  per-byte-lane compare flags for one 32-bit data word
- o_mask_valid  out  1  mask word valid
- i_mask_ready  in  1  sink accepts mask word
- o_mask_word  out  32  packed mask bits; bit k = element (32*idx + k)
- o_mask_idx  out  $clog2(VLEN/32)  mask word index
- o_mask_last  out  1  final word of this build
- o_busy  out  1  build in progress
- o_done  out  1  one-cycle pulse when build completes

Behaviour:
- Reset (async, any state): FSM to IDLE; all outputs 0; accumulator, bit pointer, element counter, word index cleared.
- FSM states: IDLE, COLLECT, EMIT, DONE.
- IDLE
  - i_start with i_vl != 0: latch vl/SEW, go to COLLECT.
  - i_start with i_vl == 0: go to DONE; no word emitted.
- While not IDLE, o_busy = 1 and i_start is ignored.
- COLLECT
  - o_cmp_ready = 1; a transfer occurs when i_cmp_valid & o_cmp_ready.
  - Elements extracted per transfer, lowest element first:
    - 8b: 4 elements = i_cmp_bits[0], [1], [2], [3].
    - 16b: 2 elements = i_cmp_bits[0], [2].
    - 32b: 1 element = i_cmp_bits[0].
  - Each extracted bit is written at accumulator[ptr + n]; ptr advances by the element count; the element counter advances by the same amount.
  - Elements whose index is >= vl are written as 0 (tail zero).
  - After the transfer, go to EMIT if ptr wraps to 0 (32 bits filled) or the element counter reaches or exceeds vl. Otherwise stay in COLLECT.
- EMIT
  - o_mask_valid = 1 and o_cmp_ready = 0.
  - o_mask_word, o_mask_idx and o_mask_last are held stable until i_mask_ready.
  - o_mask_last = 1 when element counter >= vl.
  - On handshake:
    - Clear accumulator, ptr = 0, idx += 1.
    - If last, go to DONE; else go to COLLECT.
  - A partial final word has its unfilled upper bits = 0.
- DONE: o_done = 1 for one cycle, o_busy = 0, then return to IDLE.
- Latency:
  - First compare transfer occurs no earlier than the cycle after i_start.
  - o_mask_valid asserts the cycle after the filling transfer.
  - There is no combinational path from i_cmp_valid to o_mask_valid, or from i_mask_ready to o_cmp_ready.
- Word count per build: ceil(vl/32). Maximum idx = VLEN/32-1; idx does not wrap within a legal build.
- Compare words offered after vl is reached are not consumed; o_cmp_ready stays 0 until the next build.

Test Plan:
- SEW 8b, vl=32, eight transfers of 4'hF, i_mask_ready=1 -> one word 32'hFFFFFFFF, idx 0, last=1, then o_done pulse one cycle later.
- SEW 16b, vl=5, transfers 4'b0101, 4'b0100, 4'b0001 -> single word 32'h0000001B, last=1; no fourth transfer is accepted.
- SEW 32b, vl=33, 33 transfers of 4'b0001 -> word idx0 = 32'hFFFFFFFF (last=0), then word idx1 = 32'h00000001 (last=1).
- Backpressure: SEW 8b, vl=8, i_mask_ready held 0 for 3 cycles in EMIT -> o_mask_valid and o_mask_word stay stable, o_cmp_ready=0 throughout, word accepted on the 4th cycle.
- Corner cases:
  - vl=0 start -> no o_mask_valid; o_done pulses exactly once.
  - i_start during busy -> ignored, current build result unchanged.
- Reset mid-COLLECT (after 3 transfers, i_rst asserted asynchronously) -> all outputs 0 immediately.
  - A following vl=4 SEW 8b build with input 4'b1010 yields word 32'h0000000A, idx 0.

Source files
------------

// File: rtl/vector_mask_encoder.sv
// Vector mask encoder: packs per-byte-lane compare flags into a VLEN-bit
// mask (one bit per element) and streams it out as 32-bit mask words.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               one-cycle pulse; latches i_vl / i_element_width
//   i_vl                  element count (0..VLEN)
//   i_element_width       SEW code: 000 = 8b, 101 = 16b, 110 = 32b, other = 8b
//   i_cmp_valid/o_cmp_ready, i_cmp_bits   compare-flag input stream
//   o_mask_valid/i_mask_ready, o_mask_word, o_mask_idx, o_mask_last
//                         mask-word output stream
//   o_busy                build in progress
//   o_done                one-cycle pulse when a build completes
module vector_mask_encoder #(
    parameter int unsigned VLEN = 256
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [$clog2(VLEN):0]         i_vl,
    input  logic [2:0]                    i_element_width,
    input  logic                          i_cmp_valid,
    output logic                          o_cmp_ready,
    input  logic [3:0]                    i_cmp_bits,
    output logic                          o_mask_valid,
    input  logic                          i_mask_ready,
    output logic [31:0]                   o_mask_word,
    output logic [$clog2(VLEN/32)-1:0]    o_mask_idx,
    output logic                          o_mask_last,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int unsigned VL_W  = $clog2(VLEN) + 1;
    localparam int unsigned IDX_W = $clog2(VLEN / 32);
    // Element counter may overshoot vl by up to 3 in the last 8b transfer.
    localparam int unsigned CNT_W = VL_W + 1;
    localparam int unsigned PTR_W = 5;

    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [VL_W-1:0]    vl_q, vl_d;
    logic [1:0]         sew_q, sew_d;
    logic [31:0]        acc_q, acc_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;

    logic               cmp_ready_d;
    logic               mask_valid_d;
    logic               busy_d;
    logic               done_d;

    logic [2:0]         n_elem;
    logic [2:0]         stride;
    logic [1:0]         lane;

    // Elements per compare word and byte-lane stride for the latched SEW.
    always_comb begin
        n_elem = 3'd4;
        stride = 3'd1;
        case (sew_q)
            SEW_16: begin
                n_elem = 3'd2;
                stride = 3'd2;
            end
            SEW_32: begin
                n_elem = 3'd1;
                stride = 3'd4;
            end
            default: begin
                n_elem = 3'd4;
                stride = 3'd1;
            end
        endcase
    end

    // Next-state, datapath and registered-output next values.
    always_comb begin
        state_d      = state_q;
        vl_d         = vl_q;
        sew_d        = sew_q;
        acc_d        = acc_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        last_d       = last_q;
        lane         = 2'd0;
        cmp_ready_d  = 1'b0;
        mask_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    vl_d   = i_vl;
                    acc_d  = '0;
                    ptr_d  = '0;
                    cnt_d  = '0;
                    idx_d  = '0;
                    last_d = 1'b0;
                    case (i_element_width)
                        3'b101:  sew_d = SEW_16;
                        3'b110:  sew_d = SEW_32;
                        default: sew_d = SEW_8;
                    endcase
                    state_d = (i_vl == '0) ? S_DONE : S_COLLECT;
                end
            end

            S_COLLECT: begin
                // o_cmp_ready is high for the whole of COLLECT.
                if (i_cmp_valid) begin
                    for (int unsigned n = 0; n < 4; n++) begin
                        if (3'(n) < n_elem) begin
                            lane = 2'(3'(n) * stride);
                            // Elements at or beyond vl are forced to zero.
                            if (CNT_W'(cnt_q + CNT_W'(n)) < CNT_W'(vl_q)) begin
                                acc_d[PTR_W'(ptr_q + PTR_W'(n))] = i_cmp_bits[lane];
                            end else begin
                                acc_d[PTR_W'(ptr_q + PTR_W'(n))] = 1'b0;
                            end
                        end
                    end
                    ptr_d = PTR_W'(ptr_q + PTR_W'(n_elem));
                    cnt_d = CNT_W'(cnt_q + CNT_W'(n_elem));
                    if ((ptr_d == '0) || (cnt_d >= CNT_W'(vl_q))) begin
                        last_d  = (cnt_d >= CNT_W'(vl_q));
                        state_d = S_EMIT;
                    end
                end
            end

            S_EMIT: begin
                if (i_mask_ready) begin
                    acc_d   = '0;
                    ptr_d   = '0;
                    idx_d   = IDX_W'(idx_q + 1'b1);
                    last_d  = 1'b0;
                    state_d = last_q ? S_DONE : S_COLLECT;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Moore outputs follow the state being entered so they register cleanly.
        cmp_ready_d  = (state_d == S_COLLECT);
        mask_valid_d = (state_d == S_EMIT);
        busy_d       = (state_d == S_COLLECT) || (state_d == S_EMIT);
        done_d       = (state_d == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            vl_q         <= '0;
            sew_q        <= SEW_8;
            acc_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            last_q       <= 1'b0;
            o_cmp_ready  <= 1'b0;
            o_mask_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vl_q         <= vl_d;
            sew_q        <= sew_d;
            acc_q        <= acc_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            o_cmp_ready  <= cmp_ready_d;
            o_mask_valid <= mask_valid_d;
            o_busy       <= busy_d;
            o_done       <= done_d;
        end
    end

    // Accumulator and index are registers that hold steady throughout EMIT.
    assign o_mask_word = acc_q;
    assign o_mask_idx  = idx_q;
    assign o_mask_last = last_q;

endmodule

// File: tb/tb_vector_mask_encoder.sv
// Bench for vector_mask_encoder: directed builds, expected mask words
// queued by the stimulus side and checked by an independent monitor.
module tb_vector_mask_encoder;

    localparam int unsigned VLEN  = 256;
    localparam int unsigned VL_W  = $clog2(VLEN) + 1;
    localparam int unsigned IDX_W = $clog2(VLEN / 32);

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_start;
    logic [VL_W-1:0]    i_vl;
    logic [2:0]         i_element_width;
    logic               i_cmp_valid;
    logic               o_cmp_ready;
    logic [3:0]         i_cmp_bits;
    logic               o_mask_valid;
    logic               i_mask_ready;
    logic [31:0]        o_mask_word;
    logic [IDX_W-1:0]   o_mask_idx;
    logic               o_mask_last;
    logic               o_busy;
    logic               o_done;

    typedef struct packed {
        logic [31:0]      word;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] stim[$];
    int         checks = 0;
    int         errors = 0;
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    int         valid_cycles = 0;
    bit         done_expect = 1'b0;

    vector_mask_encoder #(.VLEN(VLEN)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_vl            (i_vl),
        .i_element_width (i_element_width),
        .i_cmp_valid     (i_cmp_valid),
        .o_cmp_ready     (o_cmp_ready),
        .i_cmp_bits      (i_cmp_bits),
        .o_mask_valid    (o_mask_valid),
        .i_mask_ready    (i_mask_ready),
        .o_mask_word     (o_mask_word),
        .o_mask_idx      (o_mask_idx),
        .o_mask_last     (o_mask_last),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, pops expectations on each mask handshake.
    always @(negedge i_clk) begin
        if (done_expect) begin
            check("done_after_last", 32'(o_done), 32'd1);
            done_expect = 1'b0;
        end
        if (o_mask_valid) valid_cycles++;
        if (o_done) done_cnt++;
        if (o_cmp_ready && i_cmp_valid) xfer_cnt++;
        if (o_mask_valid && i_mask_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%h required=none", o_mask_word);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mask_word", o_mask_word, e.word);
                check("mask_idx", 32'(o_mask_idx), 32'(e.idx));
                check("mask_last", 32'(o_mask_last), 32'(e.last));
                if (o_mask_last) done_expect = 1'b1;
            end
        end
    end

    task automatic start_build(input logic [2:0] sew, input logic [VL_W-1:0] vl);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_vl = vl;
        i_element_width = sew;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    // Offers every word in stim, one transfer per accepted handshake.
    task automatic feed(input bit keep_valid);
        while (stim.size() > 0) begin
            int t;
            t = 0;
            i_cmp_valid = 1'b1;
            i_cmp_bits = stim[0];
            @(negedge i_clk);
            while (!o_cmp_ready && t < 100) begin
                t++;
                @(negedge i_clk);
            end
            if (!o_cmp_ready) begin
                check("cmp_ready_timeout", 32'(o_cmp_ready), 32'd1);
                stim.delete();
            end else begin
                void'(stim.pop_front());
                @(posedge i_clk); #1;
            end
        end
        if (!keep_valid) i_cmp_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(negedge i_clk);
            t++;
        end
        repeat (3) @(negedge i_clk);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_cmp_ready"}, 32'(o_cmp_ready), 32'd0);
        check({tag, "_mask_valid"}, 32'(o_mask_valid), 32'd0);
        check({tag, "_mask_word"}, o_mask_word, 32'd0);
        check({tag, "_mask_idx"}, 32'(o_mask_idx), 32'd0);
        check({tag, "_mask_last"}, 32'(o_mask_last), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int x0;
        int v0;
        int t;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_vl = '0;
        i_element_width = 3'b000;
        i_cmp_valid = 1'b0;
        i_cmp_bits = 4'h0;
        i_mask_ready = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        // 8b, vl=32, all ones.
        d0 = done_cnt;
        exp_q.push_back('{word: 32'hFFFF_FFFF, idx: 3'd0, last: 1'b1});
        start_build(3'b000, 9'd32);
        for (int i = 0; i < 8; i++) stim.push_back(4'hF);
        feed(1'b0);
        wait_done(d0);

        // 16b, vl=5: lanes 0 and 2 carry elements; extra words must be refused.
        d0 = done_cnt;
        x0 = xfer_cnt;
        exp_q.push_back('{word: 32'h0000_001B, idx: 3'd0, last: 1'b1});
        start_build(3'b101, 9'd5);
        stim.push_back(4'b0101);
        stim.push_back(4'b0100);
        stim.push_back(4'b0001);
        feed(1'b1);
        i_cmp_bits = 4'hF;
        wait_done(d0);
        check("sew16_transfers", 32'(xfer_cnt - x0), 32'd3);
        i_cmp_valid = 1'b0;

        // 32b, vl=33: one full word then a single-bit word.
        d0 = done_cnt;
        exp_q.push_back('{word: 32'hFFFF_FFFF, idx: 3'd0, last: 1'b0});
        exp_q.push_back('{word: 32'h0000_0001, idx: 3'd1, last: 1'b1});
        start_build(3'b110, 9'd33);
        for (int i = 0; i < 33; i++) stim.push_back(4'b0001);
        feed(1'b0);
        wait_done(d0);

        // Backpressure: 8b, vl=8, sink stalls three cycles.
        d0 = done_cnt;
        exp_q.push_back('{word: 32'h0000_0096, idx: 3'd0, last: 1'b1});
        i_mask_ready = 1'b0;
        start_build(3'b000, 9'd8);
        stim.push_back(4'b0110);
        stim.push_back(4'b1001);
        feed(1'b0);
        t = 0;
        @(negedge i_clk);
        while (!o_mask_valid && t < 20) begin
            t++;
            @(negedge i_clk);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge i_clk);
            check("bp_valid", 32'(o_mask_valid), 32'd1);
            check("bp_word", o_mask_word, 32'h0000_0096);
            check("bp_cmp_ready", 32'(o_cmp_ready), 32'd0);
        end
        @(posedge i_clk); #1;
        i_mask_ready = 1'b1;
        wait_done(d0);

        // vl=0: no mask word, exactly one done pulse.
        d0 = done_cnt;
        v0 = valid_cycles;
        start_build(3'b000, 9'd0);
        wait_done(d0);
        check("vl0_no_valid", 32'(valid_cycles - v0), 32'd0);

        // Start pulse mid-build is ignored.
        d0 = done_cnt;
        exp_q.push_back('{word: 32'h0000_0053, idx: 3'd0, last: 1'b1});
        start_build(3'b000, 9'd8);
        stim.push_back(4'h3);
        feed(1'b0);
        start_build(3'b110, 9'd0);
        check("busy_during_build", 32'(o_busy), 32'd1);
        stim.push_back(4'h5);
        feed(1'b0);
        wait_done(d0);

        // Asynchronous reset in the middle of COLLECT.
        start_build(3'b000, 9'd32);
        for (int i = 0; i < 3; i++) stim.push_back(4'hF);
        feed(1'b0);
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge i_clk);
        i_rst = 1'b0;

        d0 = done_cnt;
        exp_q.push_back('{word: 32'h0000_000A, idx: 3'd0, last: 1'b1});
        start_build(3'b000, 9'd4);
        stim.push_back(4'b1010);
        feed(1'b0);
        wait_done(d0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
